spi_xfer_sequencer: RTL and testbench

//  Command/response front end sitting directly upstream of spi_top. Queues SPI transfer

---
 rtl/spi_xfer_sequencer_if.sv | 31 +++
 rtl/spi_xfer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_spi_xfer_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_sequencer_if.sv
// Command/response and spi_top-facing signal bundle for spi_xfer_sequencer.
// slave is the sequencer's view; master is the command source, response sink and spi_top model.
interface spi_xfer_sequencer_if #(
    parameter int SPI_TRF_BIT = 8
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_mode;
    logic [SPI_TRF_BIT-1:0] cmd_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SPI_TRF_BIT-1:0] rsp_data;
    logic                   rsp_timeout;
    logic [1:0]             req;
    logic [SPI_TRF_BIT-1:0] din_master;
    logic [SPI_TRF_BIT-1:0] dout_master;
    logic                   done_tx;
    logic                   done_rx;
    logic                   busy;
    logic                   err_illegal;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_data, rsp_ready, dout_master, done_tx, done_rx,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout, req, din_master, busy, err_illegal
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_data, rsp_ready, dout_master, done_tx, done_rx,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, req, din_master, busy, err_illegal
    );
endinterface

// File: rtl/spi_xfer_sequencer.sv
// Queues SPI transfer commands, runs them one at a time against spi_top,
// and collects received bytes (or timeout markers) into a response FIFO.
module spi_xfer_sequencer #(
    parameter int SPI_TRF_BIT = 8,
    parameter int CMD_DEPTH   = 4,
    parameter int RSP_DEPTH   = 4,
    parameter int IDLE_GAP    = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_xfer_sequencer_if.slave  bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int GW  = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t                 state_reg;
    logic [1:0]             req_reg;
    logic [1:0]             mode_reg;
    logic [SPI_TRF_BIT-1:0] din_reg;
    logic [SPI_TRF_BIT-1:0] rx_data_reg;
    logic [TW-1:0]          tmo_cnt_reg;
    logic [GW-1:0]          gap_cnt_reg;
    logic                   tx_seen_reg, rx_seen_reg;
    logic                   done_tx_prev_reg, done_rx_prev_reg;
    logic                   err_illegal_reg;

    logic [1:0]             cmd_mode_mem [CMD_DEPTH];
    logic [SPI_TRF_BIT-1:0] cmd_data_mem [CMD_DEPTH];
    logic [CAW-1:0]         cmd_wr_reg, cmd_rd_reg;
    logic [CAW:0]           cmd_cnt_reg;

    logic [SPI_TRF_BIT-1:0] rsp_data_mem [RSP_DEPTH];
    logic                   rsp_tmo_mem  [RSP_DEPTH];
    logic [RAW-1:0]         rsp_wr_reg, rsp_rd_reg;
    logic [RAW:0]           rsp_cnt_reg;

    logic cmd_hs, cmd_push, cmd_empty, rsp_full, rsp_pop, launch;
    logic tx_edge, rx_edge, tx_now, rx_now, complete, expired, finish, rsp_push;
    logic [1:0]             head_mode;
    logic [SPI_TRF_BIT-1:0] head_data, rsp_push_data;

    assign cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    assign cmd_push  = cmd_hs && (bus.cmd_mode != 2'd0);
    assign cmd_empty = (cmd_cnt_reg == '0);
    assign head_mode = cmd_mode_mem[cmd_rd_reg];
    assign head_data = cmd_data_mem[cmd_rd_reg];
    assign rsp_full  = (rsp_cnt_reg == (RAW+1)'(RSP_DEPTH));
    assign rsp_pop   = bus.rsp_valid && bus.rsp_ready;

    // A command that will produce a response only launches once its FIFO slot is guaranteed.
    assign launch = (state_reg == IDLE) && !cmd_empty && ((head_mode == 2'd1) || !rsp_full);

    assign tx_edge  = bus.done_tx && !done_tx_prev_reg;
    assign rx_edge  = bus.done_rx && !done_rx_prev_reg;
    assign tx_now   = tx_seen_reg || tx_edge;
    assign rx_now   = rx_seen_reg || rx_edge;
    assign complete = (!mode_reg[0] || tx_now) && (!mode_reg[1] || rx_now);
    assign expired  = (tmo_cnt_reg == TW'(TIMEOUT - 1));
    assign finish   = (state_reg == ACTIVE) && (complete || expired);
    assign rsp_push = finish && mode_reg[1];

    // The received byte is the one present when done_rx rose, even if tx completes later.
    assign rsp_push_data = !complete ? '0 : (rx_edge ? bus.dout_master : rx_data_reg);

    assign bus.cmd_ready   = (cmd_cnt_reg != (CAW+1)'(CMD_DEPTH));
    assign bus.rsp_valid   = (rsp_cnt_reg != '0);
    assign bus.rsp_data    = bus.rsp_valid ? rsp_data_mem[rsp_rd_reg] : '0;
    assign bus.rsp_timeout = bus.rsp_valid && rsp_tmo_mem[rsp_rd_reg];
    assign bus.req         = req_reg;
    assign bus.din_master  = din_reg;
    assign bus.busy        = (state_reg != IDLE) || !cmd_empty;
    assign bus.err_illegal = err_illegal_reg;

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mode_mem[cmd_wr_reg] <= bus.cmd_mode;
            cmd_data_mem[cmd_wr_reg] <= bus.cmd_data;
        end
        if (rsp_push) begin
            rsp_data_mem[rsp_wr_reg] <= rsp_push_data;
            rsp_tmo_mem[rsp_wr_reg]  <= !complete;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_wr_reg  <= '0;
            cmd_rd_reg  <= '0;
            cmd_cnt_reg <= '0;
            rsp_wr_reg  <= '0;
            rsp_rd_reg  <= '0;
            rsp_cnt_reg <= '0;
        end else begin
            if (cmd_push) cmd_wr_reg <= cmd_wr_reg + 1'b1;
            if (launch)   cmd_rd_reg <= cmd_rd_reg + 1'b1;
            case ({cmd_push, launch})
                2'b10:   cmd_cnt_reg <= cmd_cnt_reg + 1'b1;
                2'b01:   cmd_cnt_reg <= cmd_cnt_reg - 1'b1;
                default: cmd_cnt_reg <= cmd_cnt_reg;
            endcase
            if (rsp_push) rsp_wr_reg <= rsp_wr_reg + 1'b1;
            if (rsp_pop)  rsp_rd_reg <= rsp_rd_reg + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_cnt_reg <= rsp_cnt_reg + 1'b1;
                2'b01:   rsp_cnt_reg <= rsp_cnt_reg - 1'b1;
                default: rsp_cnt_reg <= rsp_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            req_reg          <= '0;
            mode_reg         <= '0;
            din_reg          <= '0;
            rx_data_reg      <= '0;
            tmo_cnt_reg      <= '0;
            gap_cnt_reg      <= '0;
            tx_seen_reg      <= 1'b0;
            rx_seen_reg      <= 1'b0;
            done_tx_prev_reg <= 1'b0;
            done_rx_prev_reg <= 1'b0;
            err_illegal_reg  <= 1'b0;
        end else begin
            done_tx_prev_reg <= bus.done_tx;
            done_rx_prev_reg <= bus.done_rx;
            err_illegal_reg  <= cmd_hs && (bus.cmd_mode == 2'd0);
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        state_reg   <= ACTIVE;
                        req_reg     <= head_mode;
                        mode_reg    <= head_mode;
                        din_reg     <= (head_mode == 2'd2) ? '0 : head_data;
                        tmo_cnt_reg <= '0;
                        tx_seen_reg <= 1'b0;
                        rx_seen_reg <= 1'b0;
                    end else begin
                        req_reg <= '0;
                    end
                end
                ACTIVE: begin
                    tx_seen_reg <= tx_now;
                    rx_seen_reg <= rx_now;
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    if (rx_edge) rx_data_reg <= bus.dout_master;
                    if (complete || expired) begin
                        req_reg     <= '0;
                        gap_cnt_reg <= '0;
                        state_reg   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GW'(IDLE_GAP - 1)) state_reg <= IDLE;
                    else gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: responses are checked by a scoreboard monitor,
// control outputs by inline checks.
module tb_spi_xfer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic       tmo;
        logic [7:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    spi_xfer_sequencer_if #(.SPI_TRF_BIT(8)) bus ();

    spi_xfer_sequencer #(
        .SPI_TRF_BIT(8), .CMD_DEPTH(4), .RSP_DEPTH(4), .IDLE_GAP(2), .TIMEOUT(4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] m, input logic [7:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = m;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_accept", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        $display("cmd mode=%0d data=0x%02h accepted", m, d);
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.req == 2'd0 && n < 100) begin
            tick();
            n++;
        end
        check("req_launch", {31'd0, (bus.req != 2'd0)}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 6000) begin
            tick();
            n++;
        end
        check("idle_reached", {31'd0, bus.busy}, 32'd0);
    endtask

    // Scoreboard: every handshaken response must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            rsp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected actual data=0x%02h tmo=%0b expected none",
                         bus.rsp_data, bus.rsp_timeout);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_timeout, bus.rsp_data} !== e) begin
                    failures++;
                    $display("FAIL rsp_data actual data=0x%02h tmo=%0b expected data=0x%02h tmo=%0b",
                             bus.rsp_data, bus.rsp_timeout, e.data, e.tmo);
                end else begin
                    $display("rsp data=0x%02h tmo=%0b ok", bus.rsp_data, bus.rsp_timeout);
                end
            end
        end
    end

    initial begin
        int n;
        bus.cmd_valid   = 1'b0;
        bus.cmd_mode    = 2'd0;
        bus.cmd_data    = 8'h00;
        bus.rsp_ready   = 1'b1;
        bus.dout_master = 8'h00;
        bus.done_tx     = 1'b0;
        bus.done_rx     = 1'b0;
        tick();
        tick();
        check("rst_req",       {30'd0, bus.req}, 32'd0);
        check("rst_din",       {24'd0, bus.din_master}, 32'd0);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data",  {24'd0, bus.rsp_data}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy}, 32'd0);
        check("rst_err",       {31'd0, bus.err_illegal}, 32'd0);
        rst = 1'b0;
        tick();

        // mode 1: transmit only, no response
        send_cmd(2'd1, 8'hA5);
        check("m1_req_before", {30'd0, bus.req}, 32'd0);
        tick();
        check("m1_req", {30'd0, bus.req}, 32'd1);
        check("m1_din", {24'd0, bus.din_master}, 32'hA5);
        bus.done_tx = 1'b1;
        tick();
        bus.done_tx = 1'b0;
        check("m1_req_done", {30'd0, bus.req}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("m1_gap_req", {30'd0, bus.req}, 32'd0);
            check("m1_no_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("m1_din_hold", {24'd0, bus.din_master}, 32'hA5);
        wait_idle();

        // mode 2: receive only, response held until consumed
        bus.rsp_ready = 1'b0;
        exp_q.push_back('{tmo: 1'b0, data: 8'h3C});
        send_cmd(2'd2, 8'h77);
        tick();
        check("m2_req", {30'd0, bus.req}, 32'd2);
        check("m2_din", {24'd0, bus.din_master}, 32'd0);
        bus.dout_master = 8'h3C;
        bus.done_rx = 1'b1;
        tick();
        bus.done_rx = 1'b0;
        bus.dout_master = 8'h00;
        check("m2_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        check("m2_rsp_popped", {31'd0, bus.rsp_valid}, 32'd0);
        wait_idle();

        // mode 3: tx first, rx five cycles later; done_tx held high counts once
        exp_q.push_back('{tmo: 1'b0, data: 8'hC3});
        send_cmd(2'd3, 8'h5A);
        wait_req();
        check("m3_req", {30'd0, bus.req}, 32'd3);
        check("m3_din", {24'd0, bus.din_master}, 32'h5A);
        bus.done_tx = 1'b1;
        tick();
        for (int k = 1; k < 5; k++) begin
            tick();
            check("m3_wait_rx", {30'd0, bus.req}, 32'd3);
        end
        bus.dout_master = 8'hC3;
        bus.done_rx = 1'b1;
        tick();
        check("m3_req_done", {30'd0, bus.req}, 32'd0);
        bus.done_rx = 1'b0;
        bus.dout_master = 8'hFF;
        for (int k = 0; k < 4; k++) tick();
        bus.done_tx = 1'b0;
        wait_idle();

        // mode 3: rx first; the byte sampled at done_rx must be reported
        exp_q.push_back('{tmo: 1'b0, data: 8'h99});
        send_cmd(2'd3, 8'h11);
        wait_req();
        bus.dout_master = 8'h99;
        bus.done_rx = 1'b1;
        tick();
        bus.done_rx = 1'b0;
        bus.dout_master = 8'h44;
        tick();
        check("m3b_wait_tx", {30'd0, bus.req}, 32'd3);
        bus.done_tx = 1'b1;
        tick();
        bus.done_tx = 1'b0;
        check("m3b_req_done", {30'd0, bus.req}, 32'd0);
        wait_idle();

        // reset in the middle of a mode-3 transfer
        send_cmd(2'd3, 8'h77);
        tick();
        check("rst_mid_req_pre", {30'd0, bus.req}, 32'd3);
        rst = 1'b1;
        #1;
        check("rst_mid_req",       {30'd0, bus.req}, 32'd0);
        check("rst_mid_din",       {24'd0, bus.din_master}, 32'd0);
        check("rst_mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_mid_busy",      {31'd0, bus.busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        bus.dout_master = 8'hEE;
        bus.done_tx = 1'b1;
        bus.done_rx = 1'b1;
        tick();
        bus.done_tx = 1'b0;
        bus.done_rx = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_mid_req_after", {30'd0, bus.req}, 32'd0);

        // command FIFO fills: one in flight plus four queued
        for (int i = 0; i < 5; i++) send_cmd(2'd1, 8'h10 + 8'(i));
        check("fill_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("fill_busy",      {31'd0, bus.busy}, 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = 2'd1;
        bus.cmd_data  = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fill_blocked", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_req();
            check("drain_din", {24'd0, bus.din_master}, 32'h10 + 32'(i));
            bus.done_tx = 1'b1;
            tick();
            bus.done_tx = 1'b0;
            check("drain_req_done", {30'd0, bus.req}, 32'd0);
        end
        wait_idle();

        // response FIFO fills; next receive command stalls until one pop
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{tmo: 1'b0, data: 8'h80 + 8'(i)});
            send_cmd(2'd2, 8'h00);
            wait_req();
            bus.dout_master = 8'h80 + 8'(i);
            bus.done_rx = 1'b1;
            tick();
            bus.done_rx = 1'b0;
        end
        exp_q.push_back('{tmo: 1'b0, data: 8'h90});
        send_cmd(2'd2, 8'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_req", {30'd0, bus.req}, 32'd0);
        end
        check("stall_busy", {31'd0, bus.busy}, 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        check("stall_release_req", {30'd0, bus.req}, 32'd2);
        bus.dout_master = 8'h90;
        bus.done_rx = 1'b1;
        tick();
        bus.done_rx = 1'b0;
        bus.rsp_ready = 1'b1;
        n = 0;
        while (bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        check("stall_drained", {31'd0, bus.rsp_valid}, 32'd0);
        wait_idle();

        // timeout: mode 2 with no done for TIMEOUT cycles
        exp_q.push_back('{tmo: 1'b1, data: 8'h00});
        send_cmd(2'd2, 8'h00);
        tick();
        check("tmo_req", {30'd0, bus.req}, 32'd2);
        n = 0;
        while (bus.req != 2'd0 && n < 5000) begin
            tick();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd4096);
        wait_idle();

        // illegal mode-0 command
        send_cmd(2'd0, 8'h42);
        check("ill_pulse", {31'd0, bus.err_illegal}, 32'd1);
        check("ill_req",   {30'd0, bus.req}, 32'd0);
        tick();
        check("ill_pulse_end", {31'd0, bus.err_illegal}, 32'd0);
        check("ill_not_queued", {31'd0, bus.busy}, 32'd0);
        for (int k = 0; k < 3; k++) tick();
        check("ill_req_after", {30'd0, bus.req}, 32'd0);

        for (int k = 0; k < 5; k++) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
